lpc_synth: RTL
==============

Name: lpc_synth

Overview:
- All-pole LPC synthesis filter: the decoder-side counterpart to the Levinson coefficient solver.
- Takes predictor coefficients a[1..ORDER], as produced by the Levinson recursion, and reconstructs samples from a residual stream: y[n] = e[n] - sum_{k=1..ORDER} a[k]*y[n-k].
- Uses one shared multiplier, iterating one tap per clock.
- Sits between the residual decoder and the sample output path.

Parameters:
- ORDER, 10, number of predictor taps (2..32).
- DW, 16, residual/sample width, signed.
- CW, 32, coefficient width, signed.
- CFRAC, 27, coefficient fractional bits (1.0 = 2^27).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coef_we  in  1  coefficient write strobe.
- coef_idx  in  clog2(ORDER)  tap index; 0 selects a[1].
- coef_data  in  CW  coefficient value.
- coef_ready  out  1  high when coefficient writes are accepted (IDLE only).
- hist_clr  in  1  synchronous clear of sample history; honoured in IDLE only.
- in_valid  in  1  residual e[n] valid.
- in_ready  out  1  block accepts residual.
- in_data  in  DW  residual e[n].
- out_valid  out  1  y[n] valid.
- out_ready  in  1  downstream accepts y[n].
- out_data  out  DW  reconstructed sample y[n].

Behaviour:
- Reset values:
  - state=IDLE.
  - coefficient file, history, accumulator and out_data all 0.
  - out_valid=0, in_ready=1, coef_ready=1.
- IDLE:
  - in_ready=1, coef_ready=1.
  - coef_we writes coef_data to coef[coef_idx]; coef_idx>=ORDER is ignored.
  - hist_clr zeroes all history.
  - in_valid&&in_ready latches e[n]; acc <= e[n] sign-extended; tap<=0; go to MAC.
  - If coef_we and in_valid occur in the same cycle, the coefficient write applies before the sample's first tap.
- MAC, one tap per cycle for tap=0..ORDER-1:
  - p = coef[tap]*hist[tap], full DW+CW bits.
  - Truncate toward zero: for p<0, (p-1)>>>CFRAC then +1; for p>=0, p>>>CFRAC.
  - acc <= acc - p_trunc.
  - Accumulator width DW+CW-CFRAC+clog2(ORDER)+1; no internal overflow.
  - After tap ORDER-1, go to OUT.
- OUT:
  - out_data = acc saturated to [-2^(DW-1), 2^(DW-1)-1]; out_valid=1.
  - On out_valid&&out_ready: history shifts (hist[0]<=y[n], hist[k]<=hist[k-1]); go to IDLE.
  - out_data and out_valid hold stable while out_ready=0; unlimited backpressure allowed.
- History holds saturated output values, not the raw accumulator.
- in_ready and coef_ready are low in MAC and OUT. coef_we there is dropped silently; hist_clr there is ignored.
- Latency: input handshake at cycle 0 gives out_valid at cycle ORDER+1. Throughput is one sample per ORDER+2 cycles with out_ready held high.
- Reset mid-operation: any state returns to IDLE. History and coefficients clear; the pending sample is lost and no out_valid is produced.
- No combinational path from in_valid or out_ready to any output.

Decomposition:
- Shared package lpc_pkg holds:
  - constants: default CW and CFRAC, the 1.0 coefficient value (2^CFRAC).
  - state enum {IDLE, MAC, OUT}.
  - a saturate-to-DW function.
- Sub-module lpc_mul_trunc (combinational): signed multiply, truncate toward zero by CFRAC. It reuses the Levinson product rounding convention so encoder and decoder arithmetic match bit-exactly.

Test Plan:
- Pass-through: ORDER=10, all coef=0. Inputs 100, -7, 32767 give outputs 100, -7, 32767. out_valid arrives exactly 11 cycles after each input handshake.
- Decay: coef[0]=-2^26 (a1=-0.5), impulse 1000 then zeros. Outputs 1000, 500, 250, 125, 62, 31, 15.
- Negative rounding: same coefficients, impulse -1000. Outputs -1000, -500, -250, -125, -62, -31 (toward zero, not -63).
- Saturation: coef[0]=-2^27, inputs 30000, 30000, -32768. Outputs 30000, 32767, -1. The second output saturates and the saturated value feeds history.
- Backpressure/protocol:
  - Hold out_ready=0 for 20 cycles: out_data stable, in_ready=0 throughout.
  - coef_we issued in MAC leaves coef unchanged (read back via a follow-up pass-through check).
- Reset/clear:
  - Assert rst_n=0 at MAC tap 4: no out_valid, and the next impulse 1000 with a1=-0.5 gives 1000, 500.
  - hist_clr in IDLE between samples makes the next output equal its input.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared types, defaults and helpers for the LPC synthesis filter.
package lpc_pkg;

  localparam int CW_DEF    = 32;
  localparam int CFRAC_DEF = 27;
  localparam logic signed [CW_DEF-1:0] COEF_ONE = 1 <<< CFRAC_DEF;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

  // Clamp a wide signed value into the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/lpc_synth_if.sv
// Coefficient load, residual input and sample output streams of the LPC synthesis filter.
interface lpc_synth_if
  import lpc_pkg::*;
#(
  parameter int ORDER = 10,
  parameter int DW    = 16,
  parameter int CW    = CW_DEF
);
  localparam int IW = (ORDER > 1) ? $clog2(ORDER) : 1;

  logic                 coef_we;
  logic [IW-1:0]        coef_idx;
  logic signed [CW-1:0] coef_data;
  logic                 coef_ready;
  logic                 hist_clr;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;

  modport master (
    output coef_we, coef_idx, coef_data, hist_clr, in_valid, in_data, out_ready,
    input  coef_ready, in_ready, out_valid, out_data
  );

  modport slave (
    input  coef_we, coef_idx, coef_data, hist_clr, in_valid, in_data, out_ready,
    output coef_ready, in_ready, out_valid, out_data
  );

endinterface

// File: rtl/lpc_mul_trunc.sv
// Signed coefficient x sample product, scaled down by CFRAC with truncation toward zero;
// bit-exact with the product rounding used by the Levinson coefficient solver.
module lpc_mul_trunc
  import lpc_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CW    = CW_DEF,
  parameter int CFRAC = CFRAC_DEF
) (
  input  logic signed [CW-1:0]          coef,
  input  logic signed [DW-1:0]          sample,
  output logic signed [DW+CW-CFRAC-1:0] prod
);
  localparam int PW = DW + CW;
  localparam int QW = DW + CW - CFRAC;
  localparam logic signed [PW:0] ONE = (PW + 1)'(1);

  // One spare bit so p - 1 cannot wrap for the most negative product.
  logic signed [PW:0] p;

  always_comb begin
    p = (PW + 1)'(coef) * (PW + 1)'(sample);
    if (p[PW]) prod = QW'(((p - ONE) >>> CFRAC) + ONE);
    else       prod = QW'(p >>> CFRAC);
  end

endmodule

// File: rtl/lpc_synth.sv
// All-pole LPC synthesis filter: y[n] = e[n] - sum a[k]*y[n-k], one tap per clock
// through a single shared multiplier.
module lpc_synth
  import lpc_pkg::*;
#(
  parameter int ORDER = 10,
  parameter int DW    = 16,
  parameter int CW    = CW_DEF,
  parameter int CFRAC = CFRAC_DEF
) (
  input logic        clk,
  input logic        rst_n,
  lpc_synth_if.slave bus
);
  localparam int IW = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam int PW = DW + CW - CFRAC;
  localparam int AW = PW + $clog2(ORDER) + 1;

  state_e               state_q, state_d;
  logic [IW-1:0]        tap_q, tap_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [CW-1:0] coef_q [ORDER];
  logic signed [CW-1:0] coef_d [ORDER];
  logic signed [DW-1:0] hist_q [ORDER];
  logic signed [DW-1:0] hist_d [ORDER];
  logic signed [DW-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [PW-1:0] p_trunc;

  lpc_mul_trunc #(.DW(DW), .CW(CW), .CFRAC(CFRAC)) u_mul (
    .coef   (coef_q[tap_q]),
    .sample (hist_q[tap_q]),
    .prod   (p_trunc)
  );

  // Handshake readies decode the state flop only, so no input reaches an output combinationally.
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.coef_ready = (state_q == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;

  always_comb begin
    // NOTE: every *_d takes its held value first, so no path through this block infers a latch.
    state_d     = state_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    coef_d      = coef_q;
    hist_d      = hist_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.coef_we && (32'(bus.coef_idx) < ORDER)) coef_d[bus.coef_idx] = bus.coef_data;
        if (bus.hist_clr) begin
          for (int k = 0; k < ORDER; k++) hist_d[k] = '0;
        end
        if (bus.in_valid) begin
          acc_d   = AW'(bus.in_data);
          tap_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q - AW'(p_trunc);
        if (32'(tap_q) == ORDER - 1) begin
          out_data_d  = DW'(sat_dw(64'(acc_d), DW));
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          tap_d = tap_q + IW'(1);
        end
      end
      OUT: begin
        // History is fed the saturated sample, matching what the listener hears.
        if (bus.out_ready) begin
          hist_d[0] = out_data_q;
          for (int k = 1; k < ORDER; k++) hist_d[k] = hist_q[k-1];
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      // NOTE: both arrays are reset explicitly; a reset mid-stream must not leave stale taps or history.
      for (int k = 0; k < ORDER; k++) begin
        coef_q[k] <= '0;
        hist_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments only here, so every flop samples the pre-edge *_d values.
      state_q     <= state_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      coef_q      <= coef_d;
      hist_q      <= hist_d;
    end
  end

endmodule
